i2c_master: RTL and testbench

//  I2C bus initiator that drives SCL/SDA into I2C_Module, replacing the scripted

---
 rtl/i2c_master.sv | 176 +++++++++++++++++
 tb/tb_i2c_master.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
// i2c_master: I2C initiator running one 16-bit register write or read
// per request over a wired-AND SDA line; SCL divided down from CLK.
module i2c_master #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         CLK_DIV  = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        start,
    input  logic        RNW,
    input  logic [7:0]  ADDR,
    input  logic [15:0] WR_DATA,
    output logic [15:0] RD_DATA,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic        SCL,
    output logic        oSDA,
    input  logic        iSDA
);

    typedef enum logic [4:0] {
        IDLE, START, DEVW, ACK1, REG, ACK2,
        WHI, ACK3, WLO, ACK4,
        RSTART, DEVR, ACK3R, RHI, MACK, RLO, MNACK,
        STOP
    } state_t;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] DEVW_BYTE = {DEV_ADDR, 1'b0};
    localparam logic [7:0] DEVR_BYTE = {DEV_ADDR, 1'b1};

    state_t      state;
    state_t      nState;
    logic [1:0]  phase;
    logic [1:0]  nPhase;
    logic [7:0]  div;
    logic [7:0]  nDiv;
    logic [2:0]  bitCnt;
    logic [2:0]  nBit;
    logic        rnwQ;
    logic [7:0]  addrQ;
    logic [15:0] wrQ;
    logic [15:0] shiftQ;
    logic        ackIn;
    logic [7:0]  txByte;
    logic        nScl;
    logic        nSda;
    logic        phaseEnd;
    logic        slotEnd;
    logic        sampleNow;
    logic        accept;
    logic        isByte;
    logic        isAck;

    assign phaseEnd  = (div == DIV_LAST);
    assign slotEnd   = phaseEnd && (phase == 2'd3);
    assign sampleNow = phaseEnd && (phase == 2'd2);
    assign accept    = (state == IDLE) && start;

    assign isByte = (state == DEVW) || (state == REG) || (state == WHI) ||
                    (state == WLO) || (state == DEVR) || (state == RHI) ||
                    (state == RLO);
    assign isAck  = (state == ACK1) || (state == ACK2) || (state == ACK3) ||
                    (state == ACK4) || (state == ACK3R);

    // Slot sequencing; the 3-bit counter wraps 0->7 so no reload is needed.
    always_comb begin
        nState = state;
        nBit   = bitCnt;
        nDiv   = phaseEnd ? 8'd0 : div + 8'd1;
        nPhase = phaseEnd ? phase + 2'd1 : phase;
        if (state == IDLE) begin
            nDiv   = 8'd0;
            nPhase = 2'd0;
            if (start) nState = START;
        end else if (slotEnd) begin
            unique case (state)
                START:  nState = DEVW;
                DEVW:   if (bitCnt == 3'd0) nState = ACK1;
                REG:    if (bitCnt == 3'd0) nState = ACK2;
                WHI:    if (bitCnt == 3'd0) nState = ACK3;
                WLO:    if (bitCnt == 3'd0) nState = ACK4;
                DEVR:   if (bitCnt == 3'd0) nState = ACK3R;
                RHI:    if (bitCnt == 3'd0) nState = MACK;
                RLO:    if (bitCnt == 3'd0) nState = MNACK;
                ACK1:   nState = ackIn ? STOP : REG;
                ACK2:   nState = ackIn ? STOP : (rnwQ ? RSTART : WHI);
                ACK3:   nState = ackIn ? STOP : WLO;
                ACK4:   nState = STOP;
                ACK3R:  nState = ackIn ? STOP : RHI;
                RSTART: nState = DEVR;
                MACK:   nState = RLO;
                MNACK:  nState = STOP;
                STOP:   nState = IDLE;
                default: nState = IDLE;
            endcase
            if (isByte) nBit = bitCnt - 3'd1;
        end
    end

    // Line levels for the position being entered, so outputs are registered.
    always_comb begin
        txByte = 8'hFF;
        unique case (nState)
            DEVW:    txByte = DEVW_BYTE;
            REG:     txByte = addrQ;
            WHI:     txByte = wrQ[15:8];
            WLO:     txByte = wrQ[7:0];
            DEVR:    txByte = DEVR_BYTE;
            default: txByte = 8'hFF;
        endcase
        nScl = nPhase[1];
        nSda = 1'b1;
        unique case (nState)
            IDLE:   nScl = 1'b1;
            START: begin
                nScl = 1'b1;
                nSda = !nPhase[1];
            end
            RSTART: begin
                nScl = (nPhase != 2'd0);
                nSda = !nPhase[1];
            end
            STOP: begin
                nScl = (nPhase != 2'd0);
                nSda = nPhase[1];
            end
            MACK:   nSda = 1'b0;
            DEVW, REG, WHI, WLO, DEVR: nSda = txByte[nBit];
            default: nSda = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= IDLE;
            phase   <= 2'd0;
            div     <= 8'd0;
            bitCnt  <= 3'd7;
            SCL     <= 1'b1;
            oSDA    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
            RD_DATA <= 16'd0;
            ackIn   <= 1'b1;
            shiftQ  <= 16'd0;
            rnwQ    <= 1'b0;
            addrQ   <= 8'd0;
            wrQ     <= 16'd0;
        end else begin
            state  <= nState;
            phase  <= nPhase;
            div    <= nDiv;
            bitCnt <= nBit;
            SCL    <= nScl;
            oSDA   <= nSda;
            busy   <= (nState != IDLE);
            done   <= (nState == STOP) && (nPhase == 2'd3) &&
                      (nDiv == DIV_LAST);
            if (accept) begin
                rnwQ    <= RNW;
                addrQ   <= ADDR;
                wrQ     <= WR_DATA;
                ack_err <= 1'b0;
            end
            if (sampleNow) ackIn <= iSDA;
            if (sampleNow && ((state == RHI) || (state == RLO)))
                shiftQ <= {shiftQ[14:0], iSDA};
            if (slotEnd && isAck && ackIn) ack_err <= 1'b1;
            if ((state == STOP) && rnwQ && !ack_err) RD_DATA <= shiftQ;
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed bench with a register-file slave on the wired-AND
// bus plus a second CLK_DIV=1 instance for the fast-divider case.
module tb_i2c_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        rnw = 1'b0;
    logic [7:0]  addr = 8'd0;
    logic [15:0] wrData = 16'd0;
    logic [15:0] rdData;
    logic        busy, done, ackErr, scl, oSda, iSda;

    logic        start1 = 1'b0;
    logic [15:0] rdData1;
    logic        busy1, done1, ackErr1, scl1, oSda1;
    logic        iSda1 = 1'b0;

    logic        sDrv = 1'b1;
    logic        nackAddr = 1'b0;
    logic [15:0] mem [256];

    int nCmp = 0;
    int nFail = 0;
    int falls = 0, rises = 0, falls1 = 0, rises1 = 0;

    always #5 clk = ~clk;

    assign iSda = oSda & sDrv;

    i2c_master dut (
        .CLK(clk), .Reset(rst), .start(start), .RNW(rnw), .ADDR(addr),
        .WR_DATA(wrData), .RD_DATA(rdData), .busy(busy), .done(done),
        .ack_err(ackErr), .SCL(scl), .oSDA(oSda), .iSDA(iSda)
    );

    i2c_master #(.CLK_DIV(1)) dut1 (
        .CLK(clk), .Reset(rst), .start(start1), .RNW(1'b0), .ADDR(8'h33),
        .WR_DATA(16'hA55A), .RD_DATA(rdData1), .busy(busy1), .done(done1),
        .ack_err(ackErr1), .SCL(scl1), .oSDA(oSda1), .iSDA(iSda1)
    );

    // Register-file slave plus SDA-while-SCL-high edge counter.
    logic       sclP = 1'b1, sdaP = 1'b1, active = 1'b0, inAck = 1'b0;
    logic       txMode = 1'b0, addrOk = 1'b0;
    logic [7:0] sh = 8'd0, ptr = 8'd0, wrHi = 8'd0;
    logic [15:0] txWord = 16'd0;
    int         nbits = 0, byteNo = 0, txCnt = 0;

    always @(negedge clk) begin
        logic b;
        b = iSda;
        if (scl && sclP && (b != sdaP)) begin
            if (!b) falls++;
            else rises++;
        end
        if (scl && sclP && sdaP && !b) begin
            active = 1'b1; nbits = 0; byteNo = 0; inAck = 1'b0;
            txMode = 1'b0; sDrv = 1'b1;
        end else if (scl && sclP && !sdaP && b) begin
            active = 1'b0; sDrv = 1'b1;
        end else if (active && scl && !sclP) begin
            if (!inAck) begin
                sh = {sh[6:0], b};
                nbits++;
            end
        end else if (active && !scl && sclP) begin
            if (inAck) begin
                inAck = 1'b0; sDrv = 1'b1;
                if (txMode && txCnt < 16) begin
                    sDrv = txWord[15]; txWord = {txWord[14:0], 1'b0}; txCnt++;
                end
            end else if (nbits == 8) begin
                nbits = 0; inAck = 1'b1; sDrv = 1'b1;
                if (!txMode) begin
                    case (byteNo)
                        0: begin
                            addrOk = (sh[7:1] == 7'h50) && !nackAddr;
                            txMode = addrOk && sh[0];
                            txWord = mem[ptr]; txCnt = 0;
                        end
                        1: ptr = sh;
                        2: wrHi = sh;
                        3: mem[ptr] = {wrHi, sh};
                        default: ;
                    endcase
                    sDrv = !addrOk;
                    byteNo++;
                end
            end else if (txMode && txCnt < 16) begin
                sDrv = txWord[15]; txWord = {txWord[14:0], 1'b0}; txCnt++;
            end
        end
        sclP = scl;
        sdaP = b;
    end

    logic scl1P = 1'b1, sda1P = 1'b1;
    always @(negedge clk) begin
        if (scl1 && scl1P && (oSda1 != sda1P)) begin
            if (!oSda1) falls1++;
            else rises1++;
        end
        scl1P = scl1;
        sda1P = oSda1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Latency counts from the accepting edge; cycle 1 is the first after it.
    task automatic runTxn(input logic r, input logic [7:0] a,
                          input logic [15:0] d, input int injAt,
                          output int lat, output logic sMack,
                          output logic sMnack);
        @(negedge clk);
        rnw = r; addr = a; wrData = d; start = 1'b1;
        lat = -1; sMack = 1'b1; sMnack = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 2000; c++) begin
            if (c == 600) sMack = oSda;
            if (c == 744) sMnack = oSda;
            if (done) begin
                lat = c;
                break;
            end
            if (injAt != 0 && c == injAt) begin
                start = 1'b1; rnw = 1'b1; addr = 8'hFF; wrData = 16'h0000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int lat, f0, r0, dn;
        logic sm, sn;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_scl", scl, 1);
        check("rst_sda", oSda, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ackerr", ackErr, 0);
        check("rst_rddata", rdData, 16'h0000);

        f0 = falls; r0 = rises;
        runTxn(1'b0, 8'h05, 16'hBEEF, 0, lat, sm, sn);
        check("wr_latency", lat, 608);
        check("wr_ackerr", ackErr, 0);
        check("wr_busy_at_done", busy, 1);
        check("wr_mem5", mem[5], 16'hBEEF);
        check("wr_start_edges", falls - f0, 1);
        check("wr_stop_edges", rises - r0, 1);
        @(negedge clk);
        check("wr_done_pulse", done, 0);
        check("wr_busy_after", busy, 0);

        f0 = falls; r0 = rises;
        runTxn(1'b1, 8'h05, 16'h0000, 0, lat, sm, sn);
        check("rd_latency", lat, 768);
        check("rd_data", rdData, 16'hBEEF);
        check("rd_ackerr", ackErr, 0);
        check("rd_mack_sda", sm, 0);
        check("rd_mnack_sda", sn, 1);
        check("rd_start_edges", falls - f0, 2);
        check("rd_stop_edges", rises - r0, 1);

        nackAddr = 1'b1;
        f0 = falls; r0 = rises;
        runTxn(1'b1, 8'h05, 16'h0000, 0, lat, sm, sn);
        check("nack_latency", lat, 176);
        check("nack_ackerr", ackErr, 1);
        check("nack_rddata", rdData, 16'hBEEF);
        check("nack_stop_edges", rises - r0, 1);
        nackAddr = 1'b0;

        runTxn(1'b0, 8'h0A, 16'h1234, 100, lat, sm, sn);
        check("inj_latency", lat, 608);
        check("inj_ackerr", ackErr, 0);
        check("inj_memA", mem[8'h0A], 16'h1234);
        check("inj_memFF", mem[8'hFF], 16'h0000);
        check("inj_rddata", rdData, 16'hBEEF);

        @(negedge clk);
        rnw = 1'b0; addr = 8'h20; wrData = 16'h5A5A; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (369) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_scl", scl, 1);
        check("rst_mid_sda", oSda, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        dn = 0;
        repeat (300) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("rst_mid_nodone", dn, 0);
        check("rst_mid_mem20", mem[8'h20], 16'h0000);
        runTxn(1'b0, 8'h21, 16'hC3C3, 0, lat, sm, sn);
        check("post_rst_latency", lat, 608);
        check("post_rst_mem21", mem[8'h21], 16'hC3C3);
        runTxn(1'b1, 8'h21, 16'h0000, 0, lat, sm, sn);
        check("post_rst_rd", rdData, 16'hC3C3);

        f0 = falls1; r0 = rises1;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 1000; c++) begin
            if (done1) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        check("div1_latency", lat, 152);
        check("div1_ackerr", ackErr1, 0);
        check("div1_start_edges", falls1 - f0, 1);
        check("div1_stop_edges", rises1 - r0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
